// File: rtl/apb_master.sv
// APB requester: turns single-beat commands into APB SETUP/ACCESS transfers,
// with a wait-state watchdog that aborts transfers the completer never finishes.
`timescale 1ns/1ps

module apb_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response side
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB side
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // A 1-bit counter is kept when the watchdog is disabled so widths stay legal.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            state_q,       state_d;
    logic                  pwrite_q,      pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic wd_expire;

    // Expires on the edge where the PREADY-low count would reach TIMEOUT_CYCLES.
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    // Completion takes priority over a watchdog expiring on the same edge.
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (wd_expire) begin
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign PSELx       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: per-transfer timing and response are predicted
// from wait-state count, direction and completer status; inputs change and outputs are sampled on negedge.
`timescale 1ns/1ps

module tb_apb_master;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp;
    int n_err;

    // Last delivered response; outputs must hold these between rsp_valid pulses.
    logic [31:0] last_rdata;
    logic        last_err;
    logic        last_to;

    apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK       (clk),
        .PRESETn    (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSELx      (psel),
        .PENABLE    (penable),
        .PWRITE     (pwrite),
        .PADDR      (paddr),
        .PWDATA     (pwdata),
        .PRDATA     (prdata),
        .PREADY     (pready),
        .PSLVERR    (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "simulation time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_held();
        check_eq("rsp_rdata_held", rsp_rdata, last_rdata);
        check_eq("rsp_err_held", {31'd0, rsp_err}, {31'd0, last_err});
        check_eq("rsp_timeout_held", {31'd0, rsp_timeout}, {31'd0, last_to});
    endtask

    task automatic check_bus(input string tag, input logic en, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wd);
        check_eq({tag, "_psel"}, {31'd0, psel}, 32'd1);
        check_eq({tag, "_penable"}, {31'd0, penable}, {31'd0, en});
        check_eq({tag, "_pwrite"}, {31'd0, pwrite}, {31'd0, wr});
        check_eq({tag, "_paddr"}, paddr, addr);
        check_eq({tag, "_pwdata"}, pwdata, wd);
        check_eq({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
        check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    // One transfer with `waits` PREADY-low ACCESS cycles before PREADY rises.
    // If waits >= TMO the completer never answers and the watchdog must abort.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic err,
                        input bit hold);
        int          n_acc;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        exp_to;

        exp_wd = wr ? wd : 32'd0;
        n_acc  = (waits < int'(TMO)) ? waits + 1 : int'(TMO);
        if (waits < int'(TMO)) begin
            exp_rd  = wr ? 32'd0 : rd;
            exp_err = err;
            exp_to  = 1'b0;
        end else begin
            exp_rd  = 32'd0;
            exp_err = 1'b1;
            exp_to  = 1'b1;
        end

        @(negedge clk);
        check_eq("idle_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("idle_psel", {31'd0, psel}, 32'd0);
        check_eq("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_held();
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        pready    = 1'($urandom);
        pslverr   = 1'($urandom);
        prdata    = $urandom;

        // SETUP: completer inputs are noise and must be ignored
        @(negedge clk);
        check_bus("setup", 1'b0, wr, addr, exp_wd);
        check_held();
        if (hold) begin
            cmd_write = 1'($urandom);
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
        end else begin
            cmd_valid = 1'b0;
        end
        pready  = 1'($urandom);
        pslverr = 1'b1;
        prdata  = $urandom;

        for (int c = 0; c < n_acc; c++) begin
            @(negedge clk);
            check_bus("access", 1'b1, wr, addr, exp_wd);
            if (c == waits) begin
                pready  = 1'b1;
                prdata  = rd;
                pslverr = err;
            end else begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom);
            end
        end

        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'($urandom);
        pslverr   = 1'($urandom);
        check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        check_eq("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
        check_eq("rsp_psel", {31'd0, psel}, 32'd0);
        check_eq("rsp_penable", {31'd0, penable}, 32'd0);
        check_eq("rsp_ready", {31'd0, cmd_ready}, 32'd1);
        last_rdata = exp_rd;
        last_err   = exp_err;
        last_to    = exp_to;
    endtask

    // Start a read that never completes, then reset after `k` ACCESS cycles.
    task automatic reset_mid_access(input int k);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        pready    = 1'b0;
        @(negedge clk);
        for (int c = 0; c < k; c++) begin
            @(negedge clk);
            check_eq("mid_penable", {31'd0, penable}, 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_psel", {31'd0, psel}, 32'd0);
        check_eq("mid_rst_penable", {31'd0, penable}, 32'd0);
        check_eq("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        last_rdata = 32'd0;
        last_err   = 1'b0;
        last_to    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            pready = 1'b1;
            check_eq("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check_eq("post_rst_psel", {31'd0, psel}, 32'd0);
            check_eq("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
            check_held();
        end
    endtask

    initial begin
        int          waits;
        logic [31:0] rd;

        n_cmp      = 0;
        n_err      = 0;
        last_rdata = 32'd0;
        last_err   = 1'b0;
        last_to    = 1'b0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b1;
        cmd_addr   = 32'h10;
        cmd_wdata  = 32'h55;
        prdata     = 32'd0;
        pready     = 1'b1;
        pslverr    = 1'b0;

        // Reset held two cycles with a pending command
        repeat (2) @(negedge clk);
        check_eq("rst_psel", {31'd0, psel}, 32'd0);
        check_eq("rst_penable", {31'd0, penable}, 32'd0);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_pwrite", {31'd0, pwrite}, 32'd0);
        check_eq("rst_paddr", paddr, 32'd0);
        check_eq("rst_pwdata", pwdata, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_held();

        xfer(1'b1, 32'h8, 32'h0000_1234, 0, 32'd0, 1'b0, 1'b0);
        xfer(1'b0, 32'h4, 32'hDEAD_BEEF, 3, 32'hCAFE_F00D, 1'b0, 1'b0);
        xfer(1'b1, 32'h0, 32'h0000_00AA, 0, 32'd0, 1'b1, 1'b0);
        xfer(1'b0, 32'h20, 32'd0, int'(TMO), 32'h1111_2222, 1'b0, 1'b0);
        xfer(1'b0, 32'h24, 32'd0, int'(TMO) - 1, 32'h3333_4444, 1'b0, 1'b1);
        xfer(1'b1, 32'h28, 32'h5555_6666, int'(TMO) + 3, 32'd0, 1'b0, 1'b1);

        reset_mid_access(2);
        xfer(1'b1, 32'hC, 32'h0BAD_CAFE, 1, 32'd0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) waits = $urandom_range(TMO - 2, TMO + 4);
            else                           waits = $urandom_range(0, 5);
            rd = $urandom;
            xfer(1'($urandom), $urandom, $urandom, waits, rd, ($urandom_range(0, 3) == 0),
                 1'($urandom));
        end

        reset_mid_access(int'($urandom_range(1, 6)));
        xfer(1'b0, 32'h30, 32'd0, 2, 32'h0123_4567, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns single-beat command requests from a local controller (bench sequencer or on-chip CPU shim) into APB SETUP/ACCESS transfers toward the APB-to-I2C completer. It owns the APB bus side (PSELx, PENABLE, PWRITE, PADDR, PWDATA) and returns read data and error status to the requester. A wait-state watchdog aborts transfers the completer never acknowledges.

## Interface
- ADDR_WIDTH, 32, width of cmd_addr/PADDR
- DATA_WIDTH, 32, width of write/read data paths
- TIMEOUT_CYCLES, 16, max ACCESS wait states (PREADY low) before abort; 0 disables watchdog
- PCLK  in  1  single clock, all logic on rising edge
- PRESETn  in  1  synchronous, active-low reset
- cmd_valid  in  1  requester has a command
- cmd_ready  out  1  block accepts command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by watchdog
- PSELx, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  completer ready
- PSLVERR  in  1  completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at an edge, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA (PWDATA=0 for reads), go SETUP.
- SETUP: PSELx=1, PENABLE=0, cmd_ready=0. Unconditionally -> ACCESS next edge; wait counter cleared.
- ACCESS: PSELx=1, PENABLE=1. PADDR/PWRITE/PWDATA stable throughout.
  - PREADY=1 at edge: complete. rsp_valid=1 next cycle; rsp_rdata=PRDATA if read else 0; rsp_err=PSLVERR; rsp_timeout=0. -> IDLE.
  - PREADY=0: wait counter +1. When counter reaches TIMEOUT_CYCLES (nonzero) at that edge: abort, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, -> IDLE.
- PSLVERR and PRDATA sampled only in ACCESS with PREADY=1; ignored otherwise.
- Counter width: $clog2(TIMEOUT_CYCLES+1), saturates; never wraps.
- No response backpressure; rsp_* outputs are registered, rsp_rdata/err/timeout hold until next rsp_valid.
- No new command accepted until back in IDLE (no back-to-back SETUP).

## Timing
- Reset (PRESETn=0 at edge): state IDLE; PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout=0; PADDR, PWDATA, rsp_rdata=0; counter 0. cmd_ready=1 in first cycle after reset release.
- Reset mid-transfer: next edge forces IDLE, PSELx/PENABLE drop, no rsp_valid for the aborted transfer.
- Zero-wait transfer: accept edge N -> SETUP cycle N+1 -> ACCESS cycle N+2 -> rsp_valid and IDLE in cycle N+3; cmd_ready high again in N+3. Throughput one transfer per 3 cycles.
- k wait states adds k cycles. Timeout: rsp_valid in the cycle after the TIMEOUT_CYCLES-th PREADY-low ACCESS cycle; ACCESS lasts exactly TIMEOUT_CYCLES cycles.
- PREADY=1 on the same edge the counter would expire: completion wins, rsp_timeout=0.
- cmd_valid while not IDLE: ignored, command not consumed.

## Test plan
- Reset: hold PRESETn=0 two cycles with cmd_valid=1 -> all outputs 0 except cmd_ready=1 after release; no PSELx.
- Zero-wait write: cmd write addr 0x8 data 0x00001234, PREADY=1 -> PSELx rises N+1, PENABLE N+2, PADDR=0x8, PWDATA=0x1234 both cycles, rsp_valid N+3, rsp_err=0.
- Read with 3 wait states: read addr 0x4, PREADY low 3 ACCESS cycles then high with PRDATA=0xCAFEF00D -> rsp_valid 6 cycles after accept, rsp_rdata=0xCAFEF00D.
- Slave error: write addr 0x0, PREADY=1 with PSLVERR=1 -> rsp_err=1, rsp_timeout=0; PSLVERR=1 during SETUP alone has no effect.
- Timeout: TIMEOUT_CYCLES=16, PREADY tied 0 -> ACCESS exactly 16 cycles, rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0; PREADY=1 on 16th cycle instead -> normal completion.
- Reset mid-ACCESS and held cmd_valid during transfer -> PSELx drops next edge, no rsp_valid; second command issued only after IDLE.
